matmul_sequencer: RTL and testbench
===================================

# matmul_sequencer

Sequencing controller for the N×N matrix multiplier. On `start` it walks all (i, j, k) index triples, reads operands A[i][k] and B[k][j] from the operand stores, accumulates each dot product with a single multiply-accumulate, and writes every result C[i][j] into the result store. It then drives the existing file writer's `start`/`done` handshake so the finished C matrix is dumped, and reports completion upstream.

## Interface
- `N`, 4: matrix dimension (N ≥ 2).
- `DATA_W`, 32: element width of A, B, C and the accumulator.
- `IDX_W`, `$clog2(N)+1`: index port width, matching the writer's `i`/`j` ports.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a multiply; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `a_i`, `a_j`  out  IDX_W  A read address (row i, column k).
- `a_data`  in  DATA_W  A[a_i][a_j], combinational, same cycle.
- `b_i`, `b_j`  out  IDX_W  B read address (row k, column j).
- `b_data`  in  DATA_W  B[b_i][b_j], combinational, same cycle.
- `c_i`, `c_j`  out  IDX_W  C write address.
- `c_data`  out  DATA_W  C write data.
- `c_we`  out  1  C write enable, one cycle per element.
- `wr_start`  out  1  to the writer's `start`; level, held.
- `wr_done`  in  1  from the writer's `done`.

## Operation
- States: IDLE, MAC, STORE, WRITE, DONE.
- IDLE: `start`=1 → MAC with i=j=k=0. Otherwise remain.
- MAC: `a_i`=i, `a_j`=k, `b_i`=k, `b_j`=j. Each cycle, `acc` ← (k==0 ? 0 : acc) + a_data·b_data, so the first cycle clears the accumulator. When k==N-1, go to STORE. Otherwise k++.
- STORE: `c_we`=1, `c_i`=i, `c_j`=j, `c_data`=acc. Then k←0 and j++. When j wraps from N-1, set j←0 and i++. When the stored element was (N-1, N-1), go to WRITE. Otherwise return to MAC.
- WRITE: `wr_start`=1 until `wr_done`=1 is sampled, then go to DONE.
- DONE: `done`=1 for one cycle, `wr_start`=0, then go to IDLE.
- Arithmetic: the product is the low DATA_W bits of the unsigned DATA_W×DATA_W multiply. The sum wraps modulo 2^DATA_W unless the macro below is defined.
- `start` outside IDLE is ignored. `wr_done` outside WRITE is ignored.
- Outside MAC, the read addresses are 0. Outside STORE, `c_we`=0.

## Timing
- Reset values: state IDLE, i=j=k=0, acc=0; `busy`, `done`, `c_we`, `wr_start`=0; all address and data outputs 0.
- Reset asserted mid-operation aborts immediately, with no partial C write after reset. A pending `wr_start` drops asynchronously.
- `start` sampled high at edge T: MAC (0,0,0) occupies cycle T+1.
- Each element takes N MAC cycles plus 1 STORE cycle. For the whole matrix that is N²(N+1) cycles; N=4 gives 80.
- WRITE lasts W ≥ 1 cycles, where W is the cycle count up to and including the one in which `wr_done` is sampled high.
- DONE follows immediately. From `start` to the `done` pulse is N²(N+1) + W + 1 cycles.
- `busy` falls in the cycle after DONE. A new `start` is accepted in that IDLE cycle at the earliest.
- C writes occur in row-major order, exactly N² writes, with no gaps other than the MAC cycles.

## Configuration
- `MATMUL_SEQ_SAT_EN` defined:
  - Any product whose upper DATA_W bits are nonzero saturates to 2^DATA_W-1.
  - Any accumulate that carries out saturates to 2^DATA_W-1 and stays there for that element.
- Not defined: plain modular product and sum, and no saturation logic is generated.

## Test plan
- A = 1..16 row-major, B = identity, N=4, `wr_done` 3 cycles after `wr_start` → C equals A; 16 `c_we` pulses in row-major order; `done` exactly 84 cycles after `start`.
- A = all 1, B = all 2 → every C element = 8; `busy` high throughout; `wr_start` held until `wr_done`.
- A[0][0] = B[0][0] = 0x0001_0000, all other elements 0 → without the macro C[0][0] = 0; with `MATMUL_SEQ_SAT_EN` C[0][0] = 0xFFFF_FFFF; all other C elements 0.
- `start` pulsed again at MAC cycle 20 and `wr_done` pulsed during MAC → both ignored; results and cycle count are unchanged.
- `rst_n` low for 2 cycles at MAC cycle 10 → all outputs 0 and no further `c_we`; a following `start` with A = 1..16, B = identity produces a correct C.
- `wr_done` held low for 50 cycles → `wr_start` stays high and `done` stays 0; `done` pulses on the cycle after `wr_done` rises.

Source files
------------

// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: start/busy/done handshake, operand store read ports,
// result store write port and file-writer handshake of the matmul sequencer.
// master = sequencer side, slave = stores / writer / upstream side.
interface matmul_sequencer_if #(
   parameter int N      = 4,
   parameter int DATA_W = 32,
   parameter int IDX_W  = $clog2(N) + 1
);
   logic              start;
   logic              busy;
   logic              done;
   logic [IDX_W-1:0]  a_i;
   logic [IDX_W-1:0]  a_j;
   logic [DATA_W-1:0] a_data;
   logic [IDX_W-1:0]  b_i;
   logic [IDX_W-1:0]  b_j;
   logic [DATA_W-1:0] b_data;
   logic [IDX_W-1:0]  c_i;
   logic [IDX_W-1:0]  c_j;
   logic [DATA_W-1:0] c_data;
   logic              c_we;
   logic              wr_start;
   logic              wr_done;

   modport master (
      input  start, a_data, b_data, wr_done,
      output busy, done, a_i, a_j, b_i, b_j, c_i, c_j, c_data, c_we, wr_start
   );

   modport slave (
      output start, a_data, b_data, wr_done,
      input  busy, done, a_i, a_j, b_i, b_j, c_i, c_j, c_data, c_we, wr_start
   );
endinterface

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks (i, j, k) over an NxN product with one MAC,
// writes each C[i][j] in row-major order, then runs the file-writer
// handshake and pulses done.
// Optional macro MATMUL_SEQ_SAT_EN: saturating product and accumulate;
// when undefined the arithmetic wraps modulo 2^DATA_W.
// All outputs are decoded from state and counters, so an asynchronous
// reset clears them (including wr_start) immediately.
module matmul_sequencer #(
   parameter int N      = 4,
   parameter int DATA_W = 32,
   parameter int IDX_W  = $clog2(N) + 1
) (
   input logic               clk,
   input logic               rst_n,
   matmul_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      MAC,
      STORE,
      WRITE,
      DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  i;
   logic [IDX_W-1:0]  j;
   logic [IDX_W-1:0]  k;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] acc_base;
   logic [DATA_W-1:0] prod;
   logic [DATA_W-1:0] mac_sum;

`ifdef MATMUL_SEQ_SAT_EN
   logic [2*DATA_W-1:0] prod_full;
   logic [DATA_W:0]     sum_ext;

   // Saturating multiply-accumulate; a carry pins the element at all-ones
   // because any later non-zero addend carries again.
   always_comb begin
      acc_base  = (k == '0) ? '0 : acc;
      prod_full = bus.a_data * bus.b_data;
      prod      = (|prod_full[2*DATA_W-1:DATA_W]) ? '1 : prod_full[DATA_W-1:0];
      sum_ext   = {1'b0, acc_base} + {1'b0, prod};
      mac_sum   = sum_ext[DATA_W] ? '1 : sum_ext[DATA_W-1:0];
   end
`else
   // Modular multiply-accumulate; first k clears the accumulator.
   always_comb begin
      acc_base = (k == '0) ? '0 : acc;
      prod     = bus.a_data * bus.b_data;
      mac_sum  = acc_base + prod;
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and output decode.
   always_comb begin
      state_nxt    = state;
      bus.busy     = (state != IDLE);
      bus.done     = 1'b0;
      bus.a_i      = '0;
      bus.a_j      = '0;
      bus.b_i      = '0;
      bus.b_j      = '0;
      bus.c_i      = '0;
      bus.c_j      = '0;
      bus.c_data   = '0;
      bus.c_we     = 1'b0;
      bus.wr_start = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = MAC;
         end
         MAC: begin
            bus.a_i = i;
            bus.a_j = k;
            bus.b_i = k;
            bus.b_j = j;
            if (k == LAST) state_nxt = STORE;
         end
         STORE: begin
            bus.c_we   = 1'b1;
            bus.c_i    = i;
            bus.c_j    = j;
            bus.c_data = acc;
            state_nxt  = (i == LAST && j == LAST) ? WRITE : MAC;
         end
         WRITE: begin
            bus.wr_start = 1'b1;
            if (bus.wr_done) state_nxt = DONE;
         end
         DONE: begin
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Index counters and accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i   <= '0;
         j   <= '0;
         k   <= '0;
         acc <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  i   <= '0;
                  j   <= '0;
                  k   <= '0;
                  acc <= '0;
               end
            end
            MAC: begin
               acc <= mac_sum;
               if (k != LAST) k <= k + 1'b1;
            end
            STORE: begin
               k <= '0;
               if (j == LAST) begin
                  j <= '0;
                  i <= i + 1'b1;
               end else begin
                  j <= j + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: scoreboard bench for matmul_sequencer (N=4, 32-bit).
// Expected C elements are computed from the A/B tables and queued in
// row-major order; the monitor pops one per c_we pulse.
module tb_matmul_sequencer;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int IW = 3;

   logic clk = 1'b0;
   logic rst_n;

   matmul_sequencer_if #(.N(N), .DATA_W(DW), .IDX_W(IW)) bus ();

   matmul_sequencer #(.N(N), .DATA_W(DW), .IDX_W(IW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          i;
      int          j;
      logic [31:0] d;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mem_a [4][4];
   logic [31:0] mem_b [4][4];
   int          errors = 0;
   int          checks = 0;

   // operand stores: combinational read
   always_comb begin
      bus.a_data = '0;
      bus.b_data = '0;
      if (bus.a_i < 3'd4 && bus.a_j < 3'd4) bus.a_data = mem_a[bus.a_i[1:0]][bus.a_j[1:0]];
      if (bus.b_i < 3'd4 && bus.b_j < 3'd4) bus.b_data = mem_b[bus.b_i[1:0]][bus.b_j[1:0]];
   end

   // file writer model: done after wr_w cycles of wr_start, plus a poke input
   int   wr_w     = 3;
   int   wcnt     = 0;
   logic wr_model = 1'b0;
   logic wr_poke  = 1'b0;
   assign bus.wr_done = wr_poke | wr_model;

   always @(negedge clk) begin
      if (bus.wr_start === 1'b1) begin
         wcnt     = wcnt + 1;
         wr_model = (wcnt >= wr_w);
      end else begin
         wcnt     = 0;
         wr_model = 1'b0;
      end
   end

   // result store monitor: compare every write against the scoreboard
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.c_we === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL c_write_extra: got write (%0d,%0d)=%h, required none",
                     bus.c_i, bus.c_j, bus.c_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (int'(bus.c_i) !== e.i || int'(bus.c_j) !== e.j || bus.c_data !== e.d) begin
               errors++;
               $display("FAIL c_write: got (%0d,%0d)=%h, required (%0d,%0d)=%h",
                        bus.c_i, bus.c_j, bus.c_data, e.i, e.j, e.d);
            end
         end
      end
   end

   task automatic push_expected();
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            logic [63:0] s;
            exp_t        e;
            s = '0;
            for (int q = 0; q < N; q++) begin
               logic [63:0] p;
               p = {32'h0, mem_a[r][q]} * {32'h0, mem_b[q][c]};
`ifdef MATMUL_SEQ_SAT_EN
               if (p[63:32] != 32'h0) p = 64'hFFFF_FFFF;
               s = s + p;
               if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`else
               s = s + p;
`endif
            end
            e.i = r;
            e.j = c;
            e.d = s[31:0];
            sb.push_back(e);
         end
      end
   endtask

   task automatic load_identity();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            mem_a[r][c] = 32'(r * N + c + 1);
            mem_b[r][c] = (r == c) ? 32'd1 : 32'd0;
         end
   endtask

   task automatic load_const(input logic [31:0] va, input logic [31:0] vb);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            mem_a[r][c] = va;
            mem_b[r][c] = vb;
         end
   endtask

   // Starts a multiply at the current negedge and follows it to the IDLE
   // cycle after done. cycles counts from the first cycle after the start edge.
   task automatic run_one(input int w, input int poke_at, output int cycles,
                          output bit busy_ok, output bit hold_ok, output bit idle_ok);
      bit seen_ws;
      wr_w      = w;
      cycles    = -1;
      busy_ok   = 1'b1;
      hold_ok   = 1'b1;
      seen_ws   = 1'b0;
      bus.start = 1'b1;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0;
         wr_poke   = 1'b0;
         if (cyc == poke_at) begin
            bus.start = 1'b1;
            wr_poke   = 1'b1;
         end
         if (bus.done === 1'b1) begin
            cycles = cyc;
            if (bus.wr_start !== 1'b0) hold_ok = 1'b0;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            break;
         end
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         if (bus.wr_start === 1'b1) seen_ws = 1'b1;
         else if (seen_ws) hold_ok = 1'b0;
      end
      bus.start = 1'b0;
      wr_poke   = 1'b0;
      @(negedge clk);
      idle_ok = (bus.busy === 1'b0 && bus.done === 1'b0 && bus.wr_start === 1'b0);
   endtask

   task automatic test_reset();
      checks++;
      if ({bus.busy, bus.done, bus.c_we, bus.wr_start} !== 4'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got busy/done/c_we/wr_start=%b, required 0000",
                  {bus.busy, bus.done, bus.c_we, bus.wr_start});
      end
      checks++;
      if ({bus.a_i, bus.a_j, bus.b_i, bus.b_j, bus.c_i, bus.c_j} !== 18'h0) begin
         errors++;
         $display("FAIL reset_addr: got %h, required 0",
                  {bus.a_i, bus.a_j, bus.b_i, bus.b_j, bus.c_i, bus.c_j});
      end
      checks++;
      if (bus.c_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_cdata: got %h, required 0", bus.c_data);
      end
   endtask

   task automatic check_run(input string name, input int cycles, input int exp_cycles,
                            input bit busy_ok, input bit hold_ok, input bit idle_ok);
      checks++;
      if (cycles !== exp_cycles) begin
         errors++;
         $display("FAIL %s_latency: got %0d cycles, required %0d", name, cycles, exp_cycles);
      end
      checks++;
      if ({busy_ok, hold_ok, idle_ok} !== 3'b111) begin
         errors++;
         $display("FAIL %s_handshake: got busy/hold/idle ok=%b, required 111",
                  name, {busy_ok, hold_ok, idle_ok});
      end
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL %s_writes: got %0d writes missing, required 0", name, sb.size());
      end
   endtask

   task automatic test_identity();
      int cy; bit b, h, id;
      load_identity();
      push_expected();
      run_one(3, 0, cy, b, h, id);
      check_run("identity", cy, 84, b, h, id);
   endtask

   task automatic test_ones();
      int cy; bit b, h, id;
      load_const(32'd1, 32'd2);
      push_expected();
      checks++;
      if (sb[0].d !== 32'd8) begin
         errors++;
         $display("FAIL ones_model: got %h, required 8", sb[0].d);
      end
      run_one(2, 0, cy, b, h, id);
      check_run("ones", cy, 83, b, h, id);
   endtask

   task automatic test_overflow();
      int cy; bit b, h, id;
      load_const(32'd0, 32'd0);
      mem_a[0][0] = 32'h0001_0000;
      mem_b[0][0] = 32'h0001_0000;
      push_expected();
      checks++;
`ifdef MATMUL_SEQ_SAT_EN
      if (sb[0].d !== 32'hFFFF_FFFF) begin
`else
      if (sb[0].d !== 32'h0) begin
`endif
         errors++;
         $display("FAIL overflow_model: got %h", sb[0].d);
      end
      run_one(1, 0, cy, b, h, id);
      check_run("overflow", cy, 82, b, h, id);
   endtask

   task automatic test_ignore();
      int cy; bit b, h, id;
      load_identity();
      push_expected();
      run_one(3, 20, cy, b, h, id);
      check_run("ignore", cy, 84, b, h, id);
   endtask

   task automatic test_reset_mid();
      int cy; bit b, h, id;
      int we_cnt;
      load_identity();
      push_expected();
      bus.start = 1'b1;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.c_we, bus.wr_start, bus.a_i, bus.a_j, bus.b_i, bus.b_j,
           bus.c_i, bus.c_j, bus.c_data} !== 54'h0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got busy=%b c_we=%b a=(%0d,%0d) b=(%0d,%0d) c_data=%h, required all 0",
                  bus.busy, bus.c_we, bus.a_i, bus.a_j, bus.b_i, bus.b_j, bus.c_data);
      end
      sb.delete();
      we_cnt = 0;
      repeat (2) begin
         @(negedge clk);
         if (bus.c_we !== 1'b0) we_cnt++;
      end
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (bus.c_we !== 1'b0 || bus.busy !== 1'b0) we_cnt++;
      end
      checks++;
      if (we_cnt !== 0) begin
         errors++;
         $display("FAIL reset_mid_quiet: got %0d active cycles, required 0", we_cnt);
      end
      push_expected();
      run_one(3, 0, cy, b, h, id);
      check_run("after_reset", cy, 84, b, h, id);
   endtask

   task automatic test_long_write();
      int cy; bit b, h, id;
      load_const(32'd3, 32'd5);
      push_expected();
      run_one(50, 0, cy, b, h, id);
      check_run("long_write", cy, 131, b, h, id);
   endtask

   task automatic test_back_to_back();
      int cy; bit b, h, id;
      load_identity();
      push_expected();
      run_one(3, 0, cy, b, h, id);
      check_run("b2b_first", cy, 84, b, h, id);
      push_expected();
      run_one(4, 0, cy, b, h, id);
      check_run("b2b_second", cy, 85, b, h, id);
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      load_const(32'd0, 32'd0);
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_identity();
      test_ones();
      test_overflow();
      test_ignore();
      test_reset_mid();
      test_long_write();
      test_back_to_back();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
